// File: rtl/alu_bist_sequencer.sv
// Self-test sequencer for the 4-bit ALU tile: sweeps every opcode/operand pair,
// streams each sampled result over valid/ready and folds it into a signature.
module alu_bist_sequencer #(
    parameter int NUM_OPS       = 13,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [7:0]  alu_ui,
    output logic [7:0]  alu_op,
    input  logic [7:0]  alu_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic [11:0] res_tag,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
);

    localparam int              WCW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WCW-1:0]  WAIT_LOAD = WCW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]      LAST_OP   = 4'(NUM_OPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_SAMPLE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t         state;
    logic [3:0]     op_cnt;
    logic [7:0]     operand;
    logic [WCW-1:0] wait_cnt;

    // Abort outranks start; the ALU-facing and result registers keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_cnt    <= '0;
            operand   <= '0;
            wait_cnt  <= '0;
            alu_ui    <= '0;
            alu_op    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            signature <= '0;
        end else if (abort) begin
            if (state != S_IDLE) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                done      <= 1'b0;
                res_valid <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_DRIVE;
                        op_cnt    <= '0;
                        operand   <= '0;
                        signature <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    alu_ui   <= operand;
                    alu_op   <= {4'b0000, op_cnt};
                    wait_cnt <= WAIT_LOAD;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= S_SAMPLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    res_data  <= alu_result;
                    res_tag   <= {op_cnt, operand};
                    res_valid <= 1'b1;
                    signature <= {signature[14:0], signature[15]} ^ {8'h00, alu_result};
                    state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        if (operand == 8'hFF && op_cnt == LAST_OP) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (operand == 8'hFF) begin
                            operand <= '0;
                            op_cnt  <= op_cnt + 1'b1;
                            state   <= S_DRIVE;
                        end else begin
                            operand <= operand + 1'b1;
                            state   <= S_DRIVE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_sequencer.sv
// Directed bench for alu_bist_sequencer with a mode-selectable ALU stub
// (all-zero, single-hit, and a small arithmetic ALU model).
module tb_alu_bist_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  alu_ui;
    logic [7:0]  alu_op;
    logic [7:0]  alu_result;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [11:0] res_tag;
    logic        busy;
    logic        done;
    logic [15:0] signature;

    int          checks;
    int          errors;
    int          mode;
    logic [54:0] outs;

    alu_bist_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .alu_ui     (alu_ui),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .busy       (busy),
        .done       (done),
        .signature  (signature)
    );

    always #5 clk = ~clk;

    assign outs = {alu_ui, alu_op, res_valid, res_data, res_tag, busy, done, signature};

    // op 0 add, 1 sub, 2 mul, 3 and, 4 or, 5 xor, else operand byte
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
        logic [7:0] xe;
        logic [7:0] ye;
        xe = {4'b0000, x};
        ye = {4'b0000, y};
        case (op)
            4'd0:    alu_f = xe + ye;
            4'd1:    alu_f = xe - ye;
            4'd2:    alu_f = xe * ye;
            4'd3:    alu_f = xe & ye;
            4'd4:    alu_f = xe | ye;
            4'd5:    alu_f = xe ^ ye;
            default: alu_f = {y, x};
        endcase
    endfunction

    always_comb begin
        alu_result = 8'h00;
        if (mode == 1) begin
            alu_result = (alu_ui == 8'h00 && alu_op == 8'h00) ? 8'h01 : 8'h00;
        end else if (mode == 2) begin
            alu_result = alu_f(alu_op[3:0], alu_ui[3:0], alu_ui[7:4]);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic r);
        start = s;
        abort = a;
        rst   = r;
    endtask

    task automatic startSweep();
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic nextBeat(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            #1;
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic runSweep(input int max_cycles, output int beats, output int tag_errs, output int done_cyc);
        beats    = 0;
        tag_errs = 0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= max_cycles; cyc++) begin
            @(posedge clk);
            #1;
            if (res_valid) begin
                if (res_tag != 12'(beats)) tag_errs++;
                beats++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        int          beats;
        int          tag_errs;
        int          data_errs;
        int          done_cyc;
        int          unstable;
        logic        ok;
        logic [7:0]  exp_data;
        logic [15:0] sig_model;
        logic [15:0] held_sig;

        checks    = 0;
        errors    = 0;
        mode      = 0;
        res_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", 64'(outs), 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'h0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] full sweep, zero ALU");
        startSweep();
        checkOutput("start_busy", 64'(busy), 64'h1);
        runSweep(14000, beats, tag_errs, done_cyc);
        checkOutput("zero_done_cycle", 64'(done_cyc), 64'd13312);
        checkOutput("zero_beats", 64'(beats), 64'd3328);
        checkOutput("zero_tag_order", 64'(tag_errs), 64'h0);
        checkOutput("zero_signature", 64'(signature), 64'h0);
        checkOutput("zero_busy_done", 64'({busy, done}), 64'h1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_hold", 64'({busy, done}), 64'h1);

        $display("[TB] full sweep, single-hit ALU");
        mode = 1;
        startSweep();
        checkOutput("restart_from_done", 64'({busy, done}), 64'h2);
        runSweep(14000, beats, tag_errs, done_cyc);
        checkOutput("hit_beats", 64'(beats), 64'd3328);
        checkOutput("hit_tag_order", 64'(tag_errs), 64'h0);
        checkOutput("hit_signature", 64'(signature), 64'h8000);

        $display("[TB] real ALU, backpressure and abort");
        mode      = 2;
        tag_errs  = 0;
        data_errs = 0;
        sig_model = 16'h0000;
        startSweep();
        for (int b = 0; b < 4096; b++) begin
            nextBeat(ok);
            if (!ok) begin
                checkOutput("beat_timeout_a", 64'h0, 64'h1);
                break;
            end
            exp_data  = alu_f(4'(b >> 8), 4'(b), 4'(b >> 4));
            if (res_tag != 12'(b)) tag_errs++;
            if (res_data != exp_data) data_errs++;
            sig_model = {sig_model[14:0], sig_model[15]} ^ {8'h00, exp_data};
            if (b == 5) begin
                res_ready = 1'b0;
                unstable  = 0;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    if ({res_valid, res_data, res_tag, alu_ui, alu_op} !== {1'b1, 8'h05, 12'h005, 8'h05, 8'h00})
                        unstable++;
                end
                res_ready = 1'b1;
                checkOutput("bp_stable_cycles", 64'(unstable), 64'h0);
            end
            if (b == 6) checkOutput("beat7_tag", 64'(res_tag), 64'h006);
            if (b == 'h053) begin
                checkOutput("op0_data", 64'(res_data), 64'h08);
                checkOutput("op0_drive", 64'({alu_ui, alu_op}), 64'h5300);
            end
            if (b == 'h123) begin
                checkOutput("pre_abort_data", 64'(res_data), 64'h01);
                checkOutput("pre_abort_sig", 64'(signature), 64'(sig_model));
                held_sig = sig_model;
                applyStimulus(1'b1, 1'b1, 1'b0);
                @(posedge clk);
                #1;
                applyStimulus(1'b0, 1'b0, 1'b0);
                checkOutput("abort_flags", 64'({busy, res_valid, done}), 64'h0);
                checkOutput("abort_hold", 64'({alu_ui, alu_op, res_data, res_tag}), 64'h23_01_01_123);
                checkOutput("abort_sig_hold", 64'(signature), 64'(held_sig));
                @(posedge clk);
                #1;
                checkOutput("abort_start_ignored", 64'(busy), 64'h0);
                break;
            end
        end
        checkOutput("real_tag_order", 64'(tag_errs), 64'h0);
        checkOutput("real_data", 64'(data_errs), 64'h0);

        $display("[TB] restart after abort, then reset mid-sweep");
        tag_errs  = 0;
        sig_model = 16'h0000;
        startSweep();
        checkOutput("restart_sig_zero", 64'(signature), 64'h0);
        for (int b = 0; b < 4096; b++) begin
            nextBeat(ok);
            if (!ok) begin
                checkOutput("beat_timeout_b", 64'h0, 64'h1);
                break;
            end
            exp_data  = alu_f(4'(b >> 8), 4'(b), 4'(b >> 4));
            if (res_tag != 12'(b)) tag_errs++;
            sig_model = {sig_model[14:0], sig_model[15]} ^ {8'h00, exp_data};
            if (b == 0) checkOutput("restart_first_tag", 64'(res_tag), 64'h000);
            if (b == 'h253) begin
                checkOutput("op2_drive", 64'({alu_ui, alu_op}), 64'h5302);
                checkOutput("op2_data", 64'(res_data), 64'h0F);
                checkOutput("op2_sig", 64'(signature), 64'(sig_model));
                applyStimulus(1'b0, 1'b0, 1'b1);
                @(posedge clk);
                #1;
                applyStimulus(1'b0, 1'b0, 1'b0);
                checkOutput("rst_mid_sweep", 64'(outs), 64'h0);
                @(posedge clk);
                #1;
                checkOutput("rst_stays_idle", 64'({busy, res_valid}), 64'h0);
                break;
            end
        end
        checkOutput("restart_tag_order", 64'(tag_errs), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_bist_sequencer.md
Name: alu_bist_sequencer

Overview:
- Initiator/driver for the 4-bit ALU tile. It sweeps every opcode and operand pair into the ALU's operand byte and opcode byte, waits a settle interval, and samples the 8-bit result.
- Each sampled result is streamed out over a valid/ready port and folded into a 16-bit signature.
- Used as on-chip self-test and as the bench-side stimulus engine for the ALU.

Parameters:
- NUM_OPS, 13, opcodes swept 0..NUM_OPS-1 (max 16).
- SETTLE_CYCLES, 1, wait cycles between driving a vector and sampling the result (min 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin sweep; accepted only in IDLE or DONE
- abort  in  1  terminate sweep, return to IDLE
- alu_ui  out  8  operand byte to ALU: [3:0]=x, [7:4]=y
- alu_op  out  8  opcode byte to ALU
- alu_result  in  8  ALU result byte
- res_valid  out  1  result beat valid
- res_ready  in  1  downstream accepts beat
- res_data  out  8  sampled result
- res_tag  out  12  {opcode[3:0], operand byte}
- busy  out  1  sweep in progress
- done  out  1  sweep complete, held until start or rst
- signature  out  16  running result signature

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst).
- Reset values: all outputs 0. State goes to IDLE. Reset wins over every other input, including mid-sweep.
- States: IDLE, DRIVE, WAIT, SAMPLE, EMIT, DONE.
- IDLE/DONE + start:
  - go to DRIVE.
  - op counter=0, operand counter=0, signature=0.
  - done=0, busy=1.
- DRIVE (1 cycle):
  - alu_ui <= operand counter; alu_op <= {4'b0, op counter}.
  - These are registered and held stable until the next DRIVE.
  - Go to WAIT.
- WAIT (SETTLE_CYCLES cycles): count down, then go to SAMPLE.
- SAMPLE (1 cycle):
  - res_data <= alu_result; res_tag <= {op, operand}; res_valid <= 1.
  - signature <= {signature[14:0], signature[15]} ^ {8'h00, alu_result}.
  - Go to EMIT.
- EMIT:
  - Hold res_valid/res_data/res_tag stable while res_ready=0.
  - On res_valid&&res_ready: res_valid <= 0.
    - If operand=255 and op=NUM_OPS-1: go to DONE.
    - Else if operand=255: operand <= 0, op++, go to DRIVE.
    - Else: operand++, go to DRIVE.
- DONE: busy=0, done=1, signature frozen. start restarts the sweep.
- Sweep order: operand inner (0x00..0xFF), opcode outer. Total NUM_OPS*256 beats (3328 at default).
- Per-vector latency with res_ready tied 1: SETTLE_CYCLES+3 cycles (DRIVE, WAIT, SAMPLE, EMIT).
- abort in any non-IDLE state, next cycle:
  - go to IDLE; busy=0, done=0, res_valid=0.
  - alu_ui/alu_op/res_data/res_tag/signature hold their last values.
  - If abort and start are both asserted: abort wins; start is ignored that cycle.
- start while busy: ignored.
- res_ready while res_valid=0: ignored.
- Counters wrap only through the explicit rules above; no beat is skipped or duplicated.

Test Plan:
1. Reset: rst=1 for 3 cycles with start=1 and abort=0 -> all outputs 0, busy=0; after rst release, start pulse -> busy=1 on next cycle.
2. Stub ALU always returns 0x00, res_ready=1, defaults:
   - done rises 13312 cycles after start accepted (3328*4).
   - exactly 3328 beats, res_tag 0x000..0xCFF in order.
   - signature=0x0000.
3. Stub returns 0x01 only for tag 0x000, else 0x00 -> final signature=0x8000 (0x0001 rotated left 3327 times, 3327 mod 16 = 15).
4. Real ALU, beat with tag 0x253 (op 2, x=3, y=5):
   - alu_ui=0x53, alu_op=0x02, res_data=0x0F.
   - tag 0x053 (op 0): res_data=0x08.
5. Backpressure: res_ready=0 for 10 cycles on the 6th beat -> res_valid, res_data, res_tag, alu_ui and alu_op stable all 10 cycles; the 7th beat carries tag 0x006.
6. Abort at tag 0x123 during EMIT -> next cycle busy=0, res_valid=0, done=0. Then start -> first beat tag 0x000, signature restarts from 0. Repeat with rst instead of abort -> all outputs 0.
